// File: rtl/fm_operator_stage.sv
// VM2413 operator stage: phase + FM offset -> log-sin -> attenuation -> exp,
// giving a signed linear sample per slot over the 4-stage slot schedule.
module fm_operator_stage #(
    parameter int unsigned NSLOT = 18,
    parameter int unsigned OUTW  = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clkena,
    input  logic [4:0]             slot,
    input  logic [1:0]             stage,
    input  logic                   rhythm,
    input  logic                   wf,
    input  logic [2:0]             fb,
    input  logic [17:0]            pgout,
    input  logic [12:0]            egout,
    output logic signed [OUTW-1:0] opout,
    output logic [4:0]             opslot,
    output logic                   opvalid
);

    localparam int unsigned NCH = NSLOT / 2;
    localparam real PI = 3.14159265358979323846;

    function automatic logic [12:0] ls_val(input int unsigned i);
        real x;
        x = -256.0 * $ln($sin((real'(i) + 0.5) * PI / 256.0)) / $ln(2.0);
        if (x > 8191.0) x = 8191.0;
        return 13'($rtoi(x + 0.5));
    endfunction

    function automatic logic [11:0] exp_val(input int unsigned k);
        return 12'($rtoi(4095.0 * $pow(2.0, -real'(k) / 256.0) + 0.5));
    endfunction

    logic [12:0] ls_rom  [128];
    logic [11:0] exp_rom [256];

    for (genvar g = 0; g < 128; g++) begin : g_ls
        localparam logic [12:0] V = ls_val(g);
        assign ls_rom[g] = V;
    end

    for (genvar g = 0; g < 256; g++) begin : g_exp
        localparam logic [11:0] V = exp_val(g);
        assign exp_rom[g] = V;
    end

    // Only one slot is ever in flight, so a single register set is shared by
    // all stages; each stage updates only the fields it owns.
    logic [4:0]             slot_q, slot_d;
    logic                   wf_q, wf_d;
    logic [12:0]            eg_q, eg_d;
    logic [8:0]             p_q, p_d;
    logic [12:0]            ls_q, ls_d;
    logic [11:0]            m_q, m_d;
    logic [5:0]             s_q, s_d;
    logic [2:0]             vld_q, vld_d;
    logic signed [OUTW-1:0] opout_q, opout_d;
    logic [4:0]             opslot_q, opslot_d;
    logic                   opvalid_q, opvalid_d;
    logic signed [OUTW-1:0] fb1_q [NCH];
    logic signed [OUTW-1:0] fb1_d [NCH];
    logic signed [OUTW-1:0] fb2_q [NCH];
    logic signed [OUTW-1:0] fb2_d [NCH];

    logic signed [OUTW:0]   fb1_x, fb2_x, fb_sum, off;
    logic [6:0]             idx;
    logic [13:0]            lsum;
    logic [11:0]            mag;
    logic signed [OUTW-1:0] samp;
    logic                   unused_pg;

    assign unused_pg = ^pgout[8:0];

    always_comb begin
        slot_d    = slot_q;
        wf_d      = wf_q;
        eg_d      = eg_q;
        p_d       = p_q;
        ls_d      = ls_q;
        m_d       = m_q;
        s_d       = s_q;
        vld_d     = vld_q;
        opout_d   = opout_q;
        opslot_d  = opslot_q;
        opvalid_d = 1'b0;
        fb1_d     = fb1_q;
        fb2_d     = fb2_q;

        fb1_x  = $signed({fb1_q[slot[4:1]][OUTW-1], fb1_q[slot[4:1]]});
        fb2_x  = $signed({fb2_q[slot[4:1]][OUTW-1], fb2_q[slot[4:1]]});
        fb_sum = fb1_x + fb2_x;
        off    = '0;
        if (rhythm && slot >= 5'd14) begin
            off = '0;
        end else if (!slot[0]) begin
            if (fb != 3'd0) off = fb_sum >>> (4'd9 - {1'b0, fb});
        end else begin
            off = fb1_x >>> 3;
        end

        idx  = p_q[7] ? ~p_q[6:0] : p_q[6:0];
        lsum = {1'b0, ls_q} + {1'b0, eg_q};

        mag = (s_q >= 6'd12) ? 12'd0 : (m_q >> s_q);
        if (wf_q && p_q[8]) mag = 12'd0;
        samp = p_q[8] ? -OUTW'(mag) : OUTW'(mag);

        if (clkena) begin
            case (stage)
                2'd0: begin
                    slot_d = slot;
                    wf_d   = wf;
                    eg_d   = egout;
                    p_d    = pgout[17:9] + off[8:0];
                    vld_d  = 3'b001;
                end
                2'd1: begin
                    ls_d  = ls_rom[idx];
                    vld_d = {1'b0, vld_q[0], 1'b0};
                end
                2'd2: begin
                    m_d   = exp_rom[lsum[7:0]];
                    s_d   = lsum[13:8];
                    vld_d = {vld_q[1], 2'b00};
                end
                default: begin
                    vld_d = 3'b000;
                    if (vld_q[2]) begin
                        opout_d   = samp;
                        opslot_d  = slot_q;
                        opvalid_d = 1'b1;
                        if (!slot_q[0]) begin
                            fb2_d[slot_q[4:1]] = fb1_q[slot_q[4:1]];
                            fb1_d[slot_q[4:1]] = samp;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q    <= '0;
            wf_q      <= 1'b0;
            eg_q      <= '0;
            p_q       <= '0;
            ls_q      <= '0;
            m_q       <= '0;
            s_q       <= '0;
            vld_q     <= '0;
            opout_q   <= '0;
            opslot_q  <= '0;
            opvalid_q <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                fb1_q[c] <= '0;
                fb2_q[c] <= '0;
            end
        end else begin
            slot_q    <= slot_d;
            wf_q      <= wf_d;
            eg_q      <= eg_d;
            p_q       <= p_d;
            ls_q      <= ls_d;
            m_q       <= m_d;
            s_q       <= s_d;
            vld_q     <= vld_d;
            opout_q   <= opout_d;
            opslot_q  <= opslot_d;
            opvalid_q <= opvalid_d;
            fb1_q     <= fb1_d;
            fb2_q     <= fb2_d;
        end
    end

    assign opout   = opout_q;
    assign opslot  = opslot_q;
    assign opvalid = opvalid_q;

endmodule

// File: tb/tb_fm_operator_stage.sv
// Self-checking bench for fm_operator_stage: directed cases plus random frames
// checked against a formula-level model of the operator and feedback memory.
module tb_fm_operator_stage;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               reset, clkena, rhythm, wf;
    logic [4:0]         slot;
    logic [1:0]         stage;
    logic [2:0]         fb;
    logic [17:0]        pgout;
    logic [12:0]        egout;
    logic signed [12:0] opout;
    logic [4:0]         opslot;
    logic               opvalid;

    int checks = 0;
    int passes = 0;
    int fb1_m [9];
    int fb2_m [9];

    fm_operator_stage #(.NSLOT(18), .OUTW(13)) dut (
        .clk(clk), .reset(reset), .clkena(clkena), .slot(slot), .stage(stage),
        .rhythm(rhythm), .wf(wf), .fb(fb), .pgout(pgout), .egout(egout),
        .opout(opout), .opslot(opslot), .opvalid(opvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int ls_ref(input int i);
        real x;
        x = -256.0 * $ln($sin((i + 0.5) * PI / 256.0)) / $ln(2.0);
        if (x > 8191.0) x = 8191.0;
        return $rtoi(x + 0.5);
    endfunction

    function automatic int exp_ref(input int k);
        return $rtoi(4095.0 * $pow(2.0, -k / 256.0) + 0.5);
    endfunction

    // Expected sample from the operator equations; updates model memory.
    task automatic predict(input int sl, input bit w, input int f, input int pg,
                           input int eg, input bit rh, output int v);
        int ch, off, p, q, i, l, mag;
        bit neg;
        ch = sl / 2;
        if (rh && sl >= 14)   off = 0;
        else if (sl % 2 == 0) off = (f == 0) ? 0 : ((fb1_m[ch] + fb2_m[ch]) >>> (9 - f));
        else                  off = fb1_m[ch] >>> 3;
        p   = (((pg / 512) + off) % 512 + 512) % 512;
        neg = (p >= 256);
        q   = p % 256;
        i   = (q >= 128) ? 255 - q : q;
        l   = ls_ref(i) + eg;
        mag = (l / 256 >= 12) ? 0 : exp_ref(l % 256) / (1 << (l / 256));
        if (w && neg) mag = 0;
        v = neg ? -mag : mag;
        if (sl % 2 == 0) begin
            fb2_m[ch] = fb1_m[ch];
            fb1_m[ch] = v;
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 9; c++) begin
            fb1_m[c] = 0;
            fb2_m[c] = 0;
        end
    endtask

    // Drives one full slot; live inputs are scrambled after stage 0.
    task automatic do_slot(input int sl, input bit w, input int f, input int pg,
                           input int eg, input bit rh, input int gate);
        int expv;
        predict(sl, w, f, pg, eg, rh, expv);
        for (int st = 0; st < 4; st++) begin
            clkena = 1'b1;
            slot   = 5'(sl);
            stage  = 2'(st);
            if (st == 0) begin
                wf = w; fb = 3'(f); pgout = 18'(pg); egout = 13'(eg); rhythm = rh;
            end else begin
                wf = 1'($urandom); fb = 3'($urandom); pgout = 18'($urandom);
                egout = 13'($urandom); rhythm = 1'($urandom);
            end
            @(posedge clk); #1;
            if (st < 3) begin
                chk("opvalid_early", int'(opvalid), 0);
                for (int g = 0; g < gate; g++) begin
                    clkena = 1'b0;
                    stage  = 2'($urandom);
                    pgout  = 18'($urandom);
                    egout  = 13'($urandom);
                    @(posedge clk); #1;
                    chk("opvalid_gated", int'(opvalid), 0);
                end
            end
        end
        chk("opvalid", int'(opvalid), 1);
        chk("opout", int'(opout), expv);
        chk("opslot", int'(opslot), sl);
        clkena = 1'b1;
    endtask

    initial begin
        reset = 1'b1; clkena = 1'b1; slot = '0; stage = '0; rhythm = 1'b0;
        wf = 1'b0; fb = '0; pgout = '0; egout = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_opout", int'(opout), 0);
        chk("reset_opslot", int'(opslot), 0);
        chk("reset_opvalid", int'(opvalid), 0);
        reset = 1'b0;

        do_slot(1, 0, 0, 128 << 9, 0, 0, 0);
        chk("peak_pos", int'(opout), 4095);
        do_slot(1, 0, 0, 384 << 9, 0, 0, 0);
        chk("peak_neg", int'(opout), -4095);
        do_slot(1, 1, 0, 384 << 9, 0, 0, 0);
        chk("halfwave", int'(opout), 0);
        do_slot(1, 0, 0, 128 << 9, 256, 0, 0);
        chk("att_256", int'(opout), 2047);
        do_slot(1, 0, 0, 128 << 9, 512, 0, 0);
        chk("att_512", int'(opout), 1023);
        do_slot(1, 0, 0, 128 << 9, 8191, 0, 0);
        chk("att_sat", int'(opout), 0);

        // Build up feedback history, then modulator fb=7 and its carrier.
        do_slot(0, 0, 0, 100 << 9, 300, 0, 0);
        do_slot(0, 0, 0, 60 << 9, 200, 0, 0);
        do_slot(0, 0, 7, 20 << 9, 0, 0, 0);
        do_slot(1, 0, 0, 50 << 9, 0, 0, 0);
        do_slot(0, 0, 7, 300 << 9, 100, 0, 0);
        do_slot(1, 0, 0, 0, 0, 0, 0);

        // Rhythm slots ignore feedback.
        do_slot(14, 0, 0, 90 << 9, 0, 0, 0);
        do_slot(15, 0, 0, 10 << 9, 0, 1, 0);
        do_slot(15, 0, 0, 10 << 9, 0, 0, 0);

        // Gated run must equal the ungated one.
        do_slot(3, 0, 0, 200 << 9, 40, 0, 0);
        do_slot(3, 0, 0, 200 << 9, 40, 0, 5);

        // Reset during stage 2 of an in-flight modulator slot.
        do_slot(0, 0, 0, 128 << 9, 0, 0, 0);
        clkena = 1'b1; slot = 5'd2; stage = 2'd0; pgout = 18'(70 << 9); egout = '0; fb = '0;
        @(posedge clk); #1;
        stage = 2'd1;
        @(posedge clk); #1;
        stage = 2'd2; reset = 1'b1;
        @(posedge clk); #1;
        clear_model();
        chk("midreset_opout", int'(opout), 0);
        chk("midreset_opslot", int'(opslot), 0);
        chk("midreset_opvalid", int'(opvalid), 0);
        reset = 1'b0; stage = 2'd3;
        @(posedge clk); #1;
        chk("partial_no_valid", int'(opvalid), 0);
        do_slot(1, 0, 0, 0, 0, 0, 0);

        for (int fr = 0; fr < 20; fr++) begin
            for (int s = 0; s < 18; s++) begin
                do_slot(s, ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
                        $urandom_range(0, (1 << 18) - 1),
                        ($urandom_range(0, 9) == 0) ? 8191 : $urandom_range(0, 1500),
                        1'($urandom), (fr == 7) ? 2 : 0);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
